// File: rtl/gpu_pkt_framer.sv
// gpu_pkt_framer: buffers a 64-bit F-engine word stream in a FIFO and frames it
// into UDP payloads (one header word followed by PAYLOAD_WORDS data words) for the
// 10GbE core TX port. Counts input words dropped when the FIFO is full.
module gpu_pkt_framer #(
  parameter int          PAYLOAD_WORDS = 128,
  parameter int          FIFO_AW       = 9,
  parameter logic [15:0] SRC_ID        = 16'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  input  logic        in_sync,
  input  logic [31:0] dest_ip,
  input  logic [15:0] dest_port,
  input  logic        ovf_clr,
  input  logic        tx_afull,
  input  logic        tx_overflow,
  output logic        tx_valid,
  output logic [63:0] tx_data,
  output logic        tx_end_of_frame,
  output logic [31:0] tx_dest_ip,
  output logic [15:0] tx_dest_port,
  output logic        fifo_ovf,
  output logic [31:0] drop_cnt,
  output logic        core_ovf,
  output logic [47:0] pkt_cnt
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] PAY_C   = (FIFO_AW + 1)'(PAYLOAD_WORDS);
  localparam logic [FIFO_AW:0] LAST_C  = (FIFO_AW + 1)'(PAYLOAD_WORDS - 1);
  localparam logic [FIFO_AW:0] ONE_C   = (FIFO_AW + 1)'(1);

  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

  state_t             state;
  logic [63:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [FIFO_AW:0]   wcnt;
  logic               sync_pend;
  logic               rd;
  logic               wr;
  logic               drop;
  logic               start;
  logic [47:0]        seq;

  // Saturating increment for the drop counter.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // The FIFO is read on the HDR cycle (first payload word) and on every PAY cycle
  // except the last, so tx_data always holds the word currently on the bus.
  assign rd    = (state == HDR) || ((state == PAY) && (wcnt != LAST_C));
  // A full FIFO still accepts a word when a read frees a slot in the same cycle.
  assign wr    = in_valid && ((count < DEPTH_C) || rd);
  assign drop  = in_valid && !wr;
  assign start = en && !tx_afull && (count >= PAY_C);
  assign seq   = sync_pend ? 48'd0 : pkt_cnt;

  // FIFO storage: data only, no reset.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= in_data;
  end

  // FIFO pointers and occupancy; simultaneous write and read leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end

  // Sticky drop/overflow status; a clear wins over a same-cycle set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_ovf <= 1'b0;
      drop_cnt <= '0;
      core_ovf <= 1'b0;
    end else if (ovf_clr) begin
      fifo_ovf <= 1'b0;
      drop_cnt <= '0;
      core_ovf <= 1'b0;
    end else begin
      if (drop) begin
        fifo_ovf <= 1'b1;
        drop_cnt <= sat_inc32(drop_cnt);
      end
      if (tx_overflow) core_ovf <= 1'b1;
    end
  end

  // Framing FSM with registered TX outputs and sequence numbering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      tx_valid        <= 1'b0;
      tx_data         <= '0;
      tx_end_of_frame <= 1'b0;
      tx_dest_ip      <= '0;
      tx_dest_port    <= '0;
      pkt_cnt         <= '0;
      sync_pend       <= 1'b0;
      wcnt            <= '0;
    end else begin
      if (in_sync) sync_pend <= 1'b1;
      case (state)
        IDLE: begin
          tx_valid        <= 1'b0;
          tx_end_of_frame <= 1'b0;
          if (start) begin
            state        <= HDR;
            tx_valid     <= 1'b1;
            tx_data      <= {seq, SRC_ID};
            tx_dest_ip   <= dest_ip;
            tx_dest_port <= dest_port;
            pkt_cnt      <= seq + 48'd1;
            // A sync arriving on the header cycle applies to the following header.
            sync_pend    <= in_sync;
          end
        end
        HDR: begin
          state           <= PAY;
          tx_data         <= mem[rd_ptr];
          wcnt            <= '0;
          tx_end_of_frame <= (LAST_C == '0);
        end
        PAY: begin
          if (wcnt == LAST_C) begin
            state           <= IDLE;
            tx_valid        <= 1'b0;
            tx_end_of_frame <= 1'b0;
          end else begin
            tx_data         <= mem[rd_ptr];
            wcnt            <= wcnt + ONE_C;
            tx_end_of_frame <= ((wcnt + ONE_C) == LAST_C);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_pkt_framer.sv
// tb_gpu_pkt_framer: directed and randomized stimulus for gpu_pkt_framer. A
// packet-level reference model (queue of accepted words, sequence counter, drop
// counter) predicts every TX word; all driving and checking runs in one initial block.
module tb_gpu_pkt_framer;

  localparam int          P   = 128;
  localparam int          AW  = 9;
  localparam int          DEP = 2 ** AW;
  localparam logic [15:0] SID = 16'hA5C3;

  logic        clk;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_sync;
  logic [31:0] dest_ip;
  logic [15:0] dest_port;
  logic        ovf_clr;
  logic        tx_afull;
  logic        tx_overflow;
  logic        tx_valid;
  logic [63:0] tx_data;
  logic        tx_end_of_frame;
  logic [31:0] tx_dest_ip;
  logic [15:0] tx_dest_port;
  logic        fifo_ovf;
  logic [31:0] drop_cnt;
  logic        core_ovf;
  logic [47:0] pkt_cnt;

  gpu_pkt_framer #(.PAYLOAD_WORDS(P), .FIFO_AW(AW), .SRC_ID(SID)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
    .in_sync(in_sync), .dest_ip(dest_ip), .dest_port(dest_port), .ovf_clr(ovf_clr),
    .tx_afull(tx_afull), .tx_overflow(tx_overflow), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_end_of_frame(tx_end_of_frame), .tx_dest_ip(tx_dest_ip),
    .tx_dest_port(tx_dest_port), .fifo_ovf(fifo_ovf), .drop_cnt(drop_cnt),
    .core_ovf(core_ovf), .pkt_cnt(pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0] exp_q[$];
  logic [47:0] seq_log[$];
  logic [31:0] ip_log[$];
  logic [47:0] next_seq;
  logic        sync_flag;
  logic [31:0] model_drops;
  logic        model_ovf;
  int          mon_idx;
  int          hdr_cnt;
  int          tx_cycles;
  logic        prev_eof;
  logic [31:0] pkt_ip;
  logic [15:0] pkt_port;
  logic [31:0] ip_prev;
  logic [15:0] port_prev;
  logic [47:0] cur_seq;
  logic [63:0] first_hdr;
  logic [63:0] last_word;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Observes outputs and inputs for the current cycle and advances the model.
  task automatic mon();
    logic [47:0] s;
    logic [63:0] w;
    if (rst) begin
      exp_q.delete();
      next_seq    = '0;
      sync_flag   = 1'b0;
      model_drops = '0;
      model_ovf   = 1'b0;
      mon_idx     = 0;
      prev_eof    = 1'b0;
      return;
    end
    if (tx_valid) begin
      tx_cycles++;
      if (mon_idx == 0) begin
        chk("idle_gap", prev_eof, 1'b0);
        s         = sync_flag ? 48'd0 : next_seq;
        next_seq  = s + 48'd1;
        sync_flag = 1'b0;
        chk("hdr_word", tx_data, {s, SID});
        chk("hdr_eof", tx_end_of_frame, 1'b0);
        chk("hdr_ip", tx_dest_ip, ip_prev);
        chk("hdr_port", tx_dest_port, port_prev);
        pkt_ip   = ip_prev;
        pkt_port = port_prev;
        cur_seq  = tx_data[63:16];
        if (hdr_cnt == 0) first_hdr = tx_data;
        seq_log.push_back(tx_data[63:16]);
        ip_log.push_back(tx_dest_ip);
        hdr_cnt++;
        mon_idx = 1;
      end else begin
        if (exp_q.size() == 0) begin
          chk("underrun", tx_data, 64'hX);
        end else begin
          w = exp_q.pop_front();
          chk("pay_word", tx_data, w);
        end
        chk("pay_eof", tx_end_of_frame, (mon_idx == P));
        chk("pay_ip", tx_dest_ip, pkt_ip);
        chk("pay_port", tx_dest_port, pkt_port);
        last_word = tx_data;
        mon_idx   = (mon_idx == P) ? 0 : mon_idx + 1;
      end
    end else if (mon_idx != 0) begin
      chk("bubble", tx_valid, 1'b1);
      mon_idx = 0;
    end
    prev_eof = tx_valid && tx_end_of_frame;
    // Input side: a word is kept when there is room or a word is being drained now.
    if (ovf_clr) begin
      model_drops = '0;
      model_ovf   = 1'b0;
    end
    if (in_valid) begin
      if ((exp_q.size() < DEP) || (tx_valid && !tx_end_of_frame)) exp_q.push_back(in_data);
      else if (!ovf_clr) begin
        model_ovf = 1'b1;
        if (model_drops != 32'hFFFF_FFFF) model_drops++;
      end
    end
    if (in_sync) sync_flag = 1'b1;
  endtask

  // One clock cycle: check at the falling edge, record edge-sampled inputs, return 1 after the rising edge.
  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    ip_prev   = dest_ip;
    port_prev = dest_port;
    #1;
  endtask

  task automatic wait_hdr(input int n, input int budget);
    int k = 0;
    while (hdr_cnt < n && k < budget) begin
      step();
      k++;
    end
    chk("hdr_timeout", (hdr_cnt >= n), 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((mon_idx != 0 || tx_valid) && k < budget) begin
      step();
      k++;
    end
    chk("idle_timeout", (mon_idx == 0), 1'b1);
  endtask

  initial begin
    int h0;
    int t0;
    int k;
    logic [31:0] ip_a;
    logic [31:0] ip_b;
    logic sync_done;

    next_seq = '0; sync_flag = 1'b0; model_drops = '0; model_ovf = 1'b0;
    mon_idx = 0; hdr_cnt = 0; tx_cycles = 0; prev_eof = 1'b0;
    pkt_ip = '0; pkt_port = '0; ip_prev = '0; port_prev = '0;
    cur_seq = '0; first_hdr = '0; last_word = '0;
    rst = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0; in_sync = 1'b0;
    dest_ip = 32'h0A00_0001; dest_port = 16'd7148; ovf_clr = 1'b0;
    tx_afull = 1'b0; tx_overflow = 1'b0;

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_data", tx_data, 64'd0);
    chk("rst_eof", tx_end_of_frame, 1'b0);
    chk("rst_ip", tx_dest_ip, 32'd0);
    chk("rst_ovf", fifo_ovf, 1'b0);
    chk("rst_drops", drop_cnt, 32'd0);
    chk("rst_core", core_ovf, 1'b0);
    chk("rst_pkt", pkt_cnt, 48'd0);
    repeat (3) step();
    rst = 1'b0;
    en  = 1'b1;

    // T1: 129 words, one packet of 1..128, word 129 left queued
    for (int i = 1; i <= 129; i++) begin
      in_valid = 1'b1;
      in_data  = 64'(i);
      step();
    end
    in_valid = 1'b0;
    wait_hdr(1, 300);
    wait_idle(300);
    repeat (5) step();
    chk("t1_hdr", first_hdr, {48'd0, SID});
    chk("t1_last", last_word, 64'd128);
    chk("t1_txcyc", tx_cycles, 129);
    chk("t1_hdrs", hdr_cnt, 1);
    chk("t1_queued", exp_q.size(), 1);
    chk("t1_pktcnt", pkt_cnt, 48'd1);

    // T2: continuous random input, three packets, destination changed mid-packet
    ip_a = $urandom; ip_b = ip_a ^ 32'h00FF_0F01;
    dest_ip = ip_a; dest_port = 16'd1000;
    for (int i = 0; i < 383; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      if (i == 200) begin
        dest_ip   = ip_b;
        dest_port = 16'd2000;
      end
      step();
    end
    in_valid = 1'b0;
    wait_hdr(4, 400);
    wait_idle(300);
    chk("t2_seq1", seq_log[1], 48'd1);
    chk("t2_seq2", seq_log[2], 48'd2);
    chk("t2_seq3", seq_log[3], 48'd3);
    chk("t2_ip1", ip_log[1], ip_a);
    chk("t2_ip2", ip_log[2], ip_b);
    chk("t2_ip3", ip_log[3], ip_b);
    chk("t2_empty", exp_q.size(), 0);

    // T3: tx_afull holds off a ready packet; raising it mid-packet does not stall
    tx_afull = 1'b1;
    t0 = tx_cycles;
    for (int i = 0; i < 200; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      step();
    end
    in_valid = 1'b0;
    repeat (10) step();
    chk("t3_hold", tx_cycles, t0);
    h0 = hdr_cnt;
    tx_afull = 1'b0;
    step();
    step();
    chk("t3_latency", hdr_cnt, h0 + 1);
    repeat (20) step();
    tx_afull = 1'b1;
    wait_idle(300);
    repeat (5) step();
    chk("t3_txcyc", tx_cycles - t0, 129);
    chk("t3_left", exp_q.size(), 72);
    tx_afull = 1'b0;

    // T5: sync pulse during the seq 7 packet
    h0 = hdr_cnt;
    sync_done = 1'b0;
    for (int i = 0; i < 568; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      in_sync  = 1'b0;
      if (!sync_done && cur_seq == 48'd7 && mon_idx >= 40) begin
        in_sync   = 1'b1;
        sync_done = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    in_sync  = 1'b0;
    wait_hdr(h0 + 5, 400);
    wait_idle(300);
    chk("t5_pulsed", sync_done, 1'b1);
    chk("t5_seq7", seq_log[h0 + 2], 48'd7);
    chk("t5_seq0", seq_log[h0 + 3], 48'd0);
    chk("t5_seq1", seq_log[h0 + 4], 48'd1);
    chk("t5_pktcnt", pkt_cnt, 48'd2);

    // T6: asynchronous reset in the middle of a payload
    for (int i = 0; i < 200; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      step();
    end
    in_valid = 1'b0;
    k = 0;
    while (!(mon_idx >= 50 && mon_idx < 100) && k < 300) begin
      step();
      k++;
    end
    chk("t6_midpay", (mon_idx >= 50 && mon_idx < 100), 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("t6_valid", tx_valid, 1'b0);
    chk("t6_pktcnt", pkt_cnt, 48'd0);
    repeat (3) step();
    rst = 1'b0;
    h0 = hdr_cnt;
    t0 = tx_cycles;
    for (int i = 0; i < P; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      step();
    end
    in_valid = 1'b0;
    wait_hdr(h0 + 1, 300);
    wait_idle(300);
    chk("t6_seq", seq_log[h0], 48'd0);
    chk("t6_txcyc", tx_cycles - t0, 129);

    // T4: overflow with the link held off, clear priority, core overflow
    tx_afull = 1'b1;
    for (int i = 0; i < DEP + 5; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      step();
    end
    in_valid = 1'b0;
    step();
    chk("t4_ovf", fifo_ovf, 1'b1);
    chk("t4_drops", drop_cnt, 32'd5);
    chk("t4_model", drop_cnt, model_drops);
    in_valid = 1'b1; in_data = 64'hDEAD; ovf_clr = 1'b1;
    step();
    in_valid = 1'b0; ovf_clr = 1'b0;
    chk("t4_clr_ovf", fifo_ovf, 1'b0);
    chk("t4_clr_drops", drop_cnt, 32'd0);
    in_valid = 1'b1; in_data = 64'hBEEF;
    step();
    in_valid = 1'b0;
    chk("t4_redrop", drop_cnt, 32'd1);
    chk("t4_reovf", fifo_ovf, 1'b1);
    tx_overflow = 1'b1;
    step();
    tx_overflow = 1'b0;
    step();
    chk("core_set", core_ovf, 1'b1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("core_clr", core_ovf, 1'b0);
    chk("t4_clr2", drop_cnt, 32'd0);

    // Drain a full FIFO while writing every cycle
    tx_afull = 1'b0;
    for (int i = 0; i < 600; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      step();
    end
    in_valid = 1'b0;
    chk("full_rw_drops", drop_cnt, model_drops);

    // Random traffic with random enable and back-pressure
    for (int i = 0; i < 2500; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      tx_afull = ($urandom_range(0, 9) < 3);
      in_valid = $urandom_range(0, 1);
      in_data  = {$urandom, $urandom};
      step();
    end
    en = 1'b1; tx_afull = 1'b0; in_valid = 1'b0;
    k = 0;
    while ((exp_q.size() >= P || mon_idx != 0 || tx_valid) && k < 3000) begin
      step();
      k++;
    end
    repeat (5) step();
    chk("rand_drain", (exp_q.size() < P), 1'b1);
    chk("rand_drops", drop_cnt, model_drops);
    chk("rand_ovf", fifo_ovf, model_ovf);
    chk("rand_idle", tx_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
